// File: rtl/fir_tap_arbiter_if.sv
// ---------------------------------------------------------------------------
// fir_tap_arbiter_if
// Purpose : bundles the two requester channels of the tap-coefficient
//           arbiter (AXI-Lite config path and FIR engine read path).
// Signals :
//   cfg_req/cfg_we/cfg_addr/cfg_wdata  config request (requester -> arbiter)
//   cfg_gnt/cfg_err                    config accept / error pulse
//   cfg_rvalid/cfg_rdata               config read return
//   eng_req/eng_addr                   engine read request
//   eng_gnt                            engine accept
//   eng_rvalid/eng_rdata               engine read return
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface fir_tap_arbiter_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   cfg_req;
    logic                   cfg_we;
    logic [pADDR_WIDTH-1:0] cfg_addr;
    logic [pDATA_WIDTH-1:0] cfg_wdata;
    logic                   cfg_gnt;
    logic                   cfg_err;
    logic                   cfg_rvalid;
    logic [pDATA_WIDTH-1:0] cfg_rdata;

    logic                   eng_req;
    logic [pADDR_WIDTH-1:0] eng_addr;
    logic                   eng_gnt;
    logic                   eng_rvalid;
    logic [pDATA_WIDTH-1:0] eng_rdata;

    modport master (
        output cfg_req, cfg_we, cfg_addr, cfg_wdata, eng_req, eng_addr,
        input  cfg_gnt, cfg_err, cfg_rvalid, cfg_rdata,
        input  eng_gnt, eng_rvalid, eng_rdata
    );

    modport slave (
        input  cfg_req, cfg_we, cfg_addr, cfg_wdata, eng_req, eng_addr,
        output cfg_gnt, cfg_err, cfg_rvalid, cfg_rdata,
        output eng_gnt, eng_rvalid, eng_rdata
    );
endinterface

// File: rtl/fir_tap_arbiter.sv
// ---------------------------------------------------------------------------
// fir_tap_arbiter
// Purpose : shares the single-port tap-coefficient BRAM between the AXI-Lite
//           config path and the FIR MAC engine. The engine has fixed priority,
//           a starvation counter lets a waiting config read through, and config
//           writes are rejected while the engine runs. BRAM commands are
//           registered; read data returns to the winner through a 2-stage tag
//           pipeline.
// Ports   :
//   axis_clk    clock
//   axis_rst_n  asynchronous active-low reset
//   ap_busy     engine running (config writes rejected)
//   bus         requester channels (fir_tap_arbiter_if.slave)
//   tap_WE      BRAM byte write enables
//   tap_EN      BRAM enable
//   tap_Di      BRAM write data
//   tap_A       BRAM byte address
//   tap_Do      BRAM read data, valid one cycle after tap_EN
// ---------------------------------------------------------------------------
module fir_tap_arbiter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int pMAX_WAIT   = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_busy,
    fir_tap_arbiter_if.slave       bus,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);

    localparam int WAIT_W = $clog2(pMAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]        WAIT_MAX  = WAIT_W'(pMAX_WAIT);
    localparam logic [pADDR_WIDTH-3:0]   TAP_LIMIT = (pADDR_WIDTH-2)'(Tape_Num);

    logic [WAIT_W-1:0]      wait_cnt;
    logic                   cfg_legal;
    logic                   cfg_reject;
    logic                   cfg_access;
    logic                   bram_access;

    logic                   s1_valid, s1_owner, s1_err;
    logic                   s2_valid, s2_owner, s2_err;
    logic [pDATA_WIDTH-1:0] read_data;
    logic [pDATA_WIDTH-1:0] cfg_rdata_q;
    logic [pDATA_WIDTH-1:0] eng_rdata_q;

    // A rejected request (bad address, or a write while the engine runs) is
    // still granted so the requester can retire it, but it never touches BRAM.
    assign cfg_legal  = (bus.cfg_addr[1:0] == 2'b00) &&
                        (bus.cfg_addr[pADDR_WIDTH-1:2] < TAP_LIMIT);
    assign cfg_reject = !cfg_legal || (bus.cfg_we && ap_busy);

    // Engine wins unless it is idle, or a config read has starved long enough.
    // Grants are gated by reset so nothing is accepted while it is asserted.
    assign bus.cfg_gnt = axis_rst_n && bus.cfg_req &&
                         (!bus.eng_req || ((wait_cnt == WAIT_MAX) && !bus.cfg_we));
    assign bus.eng_gnt = axis_rst_n && bus.eng_req && !bus.cfg_gnt;

    assign cfg_access  = bus.cfg_gnt && !cfg_reject;
    assign bram_access = cfg_access || bus.eng_gnt;

    // Starvation counter: counts cycles a config request is left waiting.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wait_cnt <= '0;
        end else if (bus.cfg_gnt) begin
            wait_cnt <= '0;
        end else if (bus.cfg_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Registered BRAM command. Address and write data hold when idle; only
    // EN/WE need to drop so the BRAM sees no access.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            tap_EN <= 1'b0;
            tap_WE <= 4'h0;
            tap_A  <= '0;
            tap_Di <= '0;
        end else begin
            tap_EN <= bram_access;
            tap_WE <= (cfg_access && bus.cfg_we) ? 4'hF : 4'h0;
            if (bram_access) begin
                tap_A <= bus.eng_gnt ? bus.eng_addr : bus.cfg_addr;
            end
            if (cfg_access && bus.cfg_we) begin
                tap_Di <= bus.cfg_wdata;
            end
        end
    end

    // Tag pipeline: stage 1 aligns with the BRAM command, stage 2 with tap_Do.
    // Owner 1 = config, 0 = engine. Errored config reads still flow through so
    // they return zero data on schedule.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            s1_valid    <= 1'b0;
            s1_owner    <= 1'b0;
            s1_err      <= 1'b0;
            s2_valid    <= 1'b0;
            s2_owner    <= 1'b0;
            s2_err      <= 1'b0;
            bus.cfg_err <= 1'b0;
        end else begin
            s1_valid    <= (bus.cfg_gnt && !bus.cfg_we) || bus.eng_gnt;
            s1_owner    <= bus.cfg_gnt;
            s1_err      <= bus.cfg_gnt && cfg_reject;
            s2_valid    <= s1_valid;
            s2_owner    <= s1_owner;
            s2_err      <= s1_err;
            bus.cfg_err <= bus.cfg_gnt && cfg_reject;
        end
    end

    // tap_Do is only valid in the stage-2 cycle, so the returned data is
    // passed straight through then and held in a register afterwards.
    assign read_data      = s2_err ? '0 : tap_Do;
    assign bus.cfg_rvalid = s2_valid && s2_owner;
    assign bus.eng_rvalid = s2_valid && !s2_owner;
    assign bus.cfg_rdata  = bus.cfg_rvalid ? read_data : cfg_rdata_q;
    assign bus.eng_rdata  = bus.eng_rvalid ? read_data : eng_rdata_q;

    // Holding registers for the last returned word of each requester.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            cfg_rdata_q <= '0;
            eng_rdata_q <= '0;
        end else begin
            cfg_rdata_q <= bus.cfg_rdata;
            eng_rdata_q <= bus.eng_rdata;
        end
    end

endmodule

// File: tb/tb_fir_tap_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_arbiter
// Purpose : directed self-checking bench for fir_tap_arbiter with a small
//           behavioural single-port BRAM (read-first, one-cycle latency).
// ---------------------------------------------------------------------------
module tb_fir_tap_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          ap_busy;
    logic [3:0]    tap_WE;
    logic          tap_EN;
    logic [DW-1:0] tap_Di;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Do;

    logic [DW-1:0] mem [16];

    int check_count;
    int error_count;

    fir_tap_arbiter_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    fir_tap_arbiter #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .Tape_Num   (11),
        .pMAX_WAIT  (4)
    ) dut (
        .axis_clk  (clk),
        .axis_rst_n(rst_n),
        .ap_busy   (ap_busy),
        .bus       (bus),
        .tap_WE    (tap_WE),
        .tap_EN    (tap_EN),
        .tap_Di    (tap_Di),
        .tap_A     (tap_A),
        .tap_Do    (tap_Do)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tap BRAM: read-first, data valid the cycle after EN.
    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) begin
                mem[tap_A[5:2]] <= tap_Di;
            end
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives every requester input in one go.
    task automatic applyStimulus(input logic creq, input logic cwe,
                                 input logic [AW-1:0] caddr, input logic [DW-1:0] cwdata,
                                 input logic ereq, input logic [AW-1:0] eaddr,
                                 input logic busy);
        bus.cfg_req   = creq;
        bus.cfg_we    = cwe;
        bus.cfg_addr  = caddr;
        bus.cfg_wdata = cwdata;
        bus.eng_req   = ereq;
        bus.eng_addr  = eaddr;
        ap_busy       = busy;
    endtask

    // Moves to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        tap_Do      = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 12'h000, '0, 1'b1, 12'h000, 1'b0);

        // Reset state, with requests present to show grants are blocked.
        step();
        #1;
        checkOutput("rst_cfg_gnt", 32'(bus.cfg_gnt), 32'd0);
        checkOutput("rst_eng_gnt", 32'(bus.eng_gnt), 32'd0);
        checkOutput("rst_tap_en", 32'(tap_EN), 32'd0);
        checkOutput("rst_tap_we", 32'(tap_WE), 32'd0);
        checkOutput("rst_tap_a", 32'(tap_A), 32'd0);
        checkOutput("rst_tap_di", tap_Di, 32'd0);
        checkOutput("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        checkOutput("rst_rvalids", {30'd0, bus.cfg_rvalid, bus.eng_rvalid}, 32'd0);
        checkOutput("rst_rdata", bus.cfg_rdata | bus.eng_rdata, 32'd0);
        idle();
        step();
        rst_n = 1'b1;
        step();

        // Test 1: idle config write of 5 to byte address 0x08.
        applyStimulus(1'b1, 1'b1, 12'h008, 32'h5, 1'b0, '0, 1'b0);
        #1;
        checkOutput("t1_cfg_gnt", 32'(bus.cfg_gnt), 32'd1);
        checkOutput("t1_eng_gnt", 32'(bus.eng_gnt), 32'd0);
        step();
        idle();
        #1;
        checkOutput("t1_tap_a", 32'(tap_A), 32'h8);
        checkOutput("t1_tap_we", 32'(tap_WE), 32'hF);
        checkOutput("t1_tap_en", 32'(tap_EN), 32'd1);
        checkOutput("t1_tap_di", tap_Di, 32'h5);
        step();
        #1;
        checkOutput("t1_idle_en", 32'(tap_EN), 32'd0);
        checkOutput("t1_no_rvalid", 32'(bus.cfg_rvalid), 32'd0);

        // Test 2: read back 0x08.
        step();
        applyStimulus(1'b1, 1'b0, 12'h008, '0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("t2_cfg_gnt", 32'(bus.cfg_gnt), 32'd1);
        step();
        idle();
        #1;
        checkOutput("t2_tap_we", 32'(tap_WE), 32'd0);
        checkOutput("t2_tap_en", 32'(tap_EN), 32'd1);
        checkOutput("t2_rvalid_early", 32'(bus.cfg_rvalid), 32'd0);
        step();
        #1;
        checkOutput("t2_cfg_rvalid", 32'(bus.cfg_rvalid), 32'd1);
        checkOutput("t2_cfg_rdata", bus.cfg_rdata, 32'h5);
        checkOutput("t2_eng_rvalid", 32'(bus.eng_rvalid), 32'd0);
        step();
        #1;
        checkOutput("t2_rvalid_drop", 32'(bus.cfg_rvalid), 32'd0);
        checkOutput("t2_rdata_hold", bus.cfg_rdata, 32'h5);

        // Test 3: engine streams address 0x04 while a config read of 0x00 waits.
        step();
        applyStimulus(1'b1, 1'b0, 12'h000, '0, 1'b1, 12'h004, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("t3_eng_gnt_%0d", i), 32'(bus.eng_gnt), 32'd1);
            checkOutput($sformatf("t3_cfg_wait_%0d", i), 32'(bus.cfg_gnt), 32'd0);
            step();
        end
        #1;
        checkOutput("t3_cfg_gnt", 32'(bus.cfg_gnt), 32'd1);
        checkOutput("t3_eng_lose", 32'(bus.eng_gnt), 32'd0);
        step();
        idle();
        #1;
        checkOutput("t3_wait_clear", 32'(dut.wait_cnt), 32'd0);
        checkOutput("t3_tap_a", 32'(tap_A), 32'h0);
        checkOutput("t3_eng_rvalid", 32'(bus.eng_rvalid), 32'd1);
        checkOutput("t3_eng_rdata", bus.eng_rdata, 32'h101);
        step();
        #1;
        checkOutput("t3_cfg_rvalid", 32'(bus.cfg_rvalid), 32'd1);
        checkOutput("t3_cfg_rdata", bus.cfg_rdata, 32'h100);
        checkOutput("t3_eng_quiet", 32'(bus.eng_rvalid), 32'd0);
        checkOutput("t3_eng_hold", bus.eng_rdata, 32'h101);

        // Test 4: write 0x04 while engine is busy is rejected.
        step();
        applyStimulus(1'b1, 1'b1, 12'h004, 32'hDEAD, 1'b0, '0, 1'b1);
        #1;
        checkOutput("t4_cfg_gnt", 32'(bus.cfg_gnt), 32'd1);
        step();
        idle();
        #1;
        checkOutput("t4_cfg_err", 32'(bus.cfg_err), 32'd1);
        checkOutput("t4_tap_we", 32'(tap_WE), 32'd0);
        checkOutput("t4_tap_en", 32'(tap_EN), 32'd0);
        step();
        #1;
        checkOutput("t4_err_pulse", 32'(bus.cfg_err), 32'd0);
        checkOutput("t4_no_rvalid", 32'(bus.cfg_rvalid), 32'd0);
        applyStimulus(1'b1, 1'b0, 12'h004, '0, 1'b0, '0, 1'b0);
        step();
        idle();
        step();
        #1;
        checkOutput("t4_readback_v", 32'(bus.cfg_rvalid), 32'd1);
        checkOutput("t4_readback", bus.cfg_rdata, 32'h101);

        // Test 5: last legal word, then out-of-range and misaligned reads.
        step();
        applyStimulus(1'b1, 1'b0, 12'h028, '0, 1'b0, '0, 1'b0);
        step();
        idle();
        #1;
        checkOutput("t5_w10_err", 32'(bus.cfg_err), 32'd0);
        step();
        #1;
        checkOutput("t5_w10_rdata", bus.cfg_rdata, 32'h10A);
        applyStimulus(1'b1, 1'b0, 12'h02C, '0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("t5_2c_gnt", 32'(bus.cfg_gnt), 32'd1);
        step();
        idle();
        #1;
        checkOutput("t5_2c_err", 32'(bus.cfg_err), 32'd1);
        checkOutput("t5_2c_tap_en", 32'(tap_EN), 32'd0);
        step();
        #1;
        checkOutput("t5_2c_rvalid", 32'(bus.cfg_rvalid), 32'd1);
        checkOutput("t5_2c_rdata", bus.cfg_rdata, 32'h0);
        applyStimulus(1'b1, 1'b0, 12'h003, '0, 1'b0, '0, 1'b0);
        step();
        idle();
        #1;
        checkOutput("t5_03_err", 32'(bus.cfg_err), 32'd1);
        checkOutput("t5_03_tap_en", 32'(tap_EN), 32'd0);
        step();
        #1;
        checkOutput("t5_03_rvalid", 32'(bus.cfg_rvalid), 32'd1);

        // Test 6: engine burst 0x00,0x04,0x08 then reset after second return.
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 12'h000, 1'b0);
        #1;
        checkOutput("t6_gnt0", 32'(bus.eng_gnt), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 12'h004, 1'b0);
        #1;
        checkOutput("t6_gnt1", 32'(bus.eng_gnt), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 12'h008, 1'b0);
        #1;
        checkOutput("t6_gnt2", 32'(bus.eng_gnt), 32'd1);
        checkOutput("t6_rv0", 32'(bus.eng_rvalid), 32'd1);
        checkOutput("t6_rd0", bus.eng_rdata, 32'h100);
        step();
        idle();
        #1;
        checkOutput("t6_rv1", 32'(bus.eng_rvalid), 32'd1);
        checkOutput("t6_rd1", bus.eng_rdata, 32'h101);
        checkOutput("t6_tap_a2", 32'(tap_A), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_rvalid", 32'(bus.eng_rvalid), 32'd0);
        checkOutput("t6_rst_rdata", bus.eng_rdata, 32'd0);
        checkOutput("t6_rst_tap_en", 32'(tap_EN), 32'd0);
        checkOutput("t6_rst_tap_a", 32'(tap_A), 32'd0);
        step();
        #1;
        checkOutput("t6_no_third_a", 32'(bus.eng_rvalid), 32'd0);
        rst_n = 1'b1;
        step();
        #1;
        checkOutput("t6_no_third_b", 32'(bus.eng_rvalid), 32'd0);
        step();
        #1;
        checkOutput("t6_no_third_c", 32'(bus.eng_rvalid | bus.cfg_rvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
